bram_delay_prog: RTL and testbench
==================================

# bram_delay_prog

Runtime-programmable, clock-enabled BRAM delay line in `general_lib`. It is the parametrised successor to the fixed-delay BRAM delay. The delay is loaded at run time between a minimum and `MAX_DELAY`, counted in `ce`-qualified cycles, with a valid flag that marks when the line is full. It sits in the X-engine datapath wherever a stream must be aligned by a delay that is set by software or a control FSM rather than at synthesis time.

## Interface
- `WIDTH`, 32: data width in bits.
- `MAX_DELAY`, 1024: largest supported delay in `ce` cycles; sets RAM depth to `MAX_DELAY-LATENCY`.
- `LATENCY`, 2: RAM read latency, 1 or 2; any other value is an elaboration error.
- `DEFAULT_DELAY`, `MAX_DELAY`: delay in force after reset.
- `DELAY_BITS`, `log2(MAX_DELAY+1)`: width of `delay`; derived, not overridden.
- `clk` in 1: clock; one clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `ce` in 1: clock enable; all delay-line state advances only when high.
- `din` in `WIDTH`: data input, sampled when `ce`=1.
- `delay` in `DELAY_BITS`: requested delay, sampled when `delay_load`=1.
- `delay_load` in 1: single-cycle load strobe.
- `dout` out `WIDTH`: delayed data; forced to 0 while `dout_valid`=0.
- `dout_valid` out 1: high once the line has filled for the current delay.
- `delay_err` out 1: one-cycle pulse when a loaded `delay` was out of range and clamped.
- `delay_cur` out `DELAY_BITS`: delay currently in force.

## Operation
- Legal range is `DMIN = LATENCY+1` to `MAX_DELAY`.
  - A loaded value below `DMIN` is clamped to `DMIN`; a value above `MAX_DELAY` is clamped to `MAX_DELAY`.
  - In both cases `delay_err` pulses in the cycle after the load.
- Address counter `ctr`, width `log2(MAX_DELAY-LATENCY)`:
  - It advances on `ce` and wraps from `delay_cur-LATENCY-1` to 0.
  - The RAM is read-before-write at `ctr`, with `we = ce & ~delay_load`.
- Fill counter `fill` runs from 0 to `delay_cur`:
  - It increments on each write cycle and saturates at `delay_cur`.
  - `dout_valid = (fill == delay_cur)`, registered and aligned with `dout`.
- When `delay_load` is high:
  - Next cycle: `delay_cur`←clamped `delay`, `ctr`←0, `fill`←0, `dout_valid`←0.
  - `din` in the load cycle is discarded, even if `ce`=1.
  - `delay_load` takes priority over `ce`.
- A load while the line is only partly filled restarts the fill. There is no partial-valid output.
- When `ce`=0:
  - `ctr`, `fill`, the RAM output pipeline, `dout` and `dout_valid` all hold.
  - `delay_load` is still honoured.
- Reset (async assert, synchronous release):
  - `ctr`=0, `fill`=0, `delay_cur`=`DEFAULT_DELAY`.
  - `dout`=0, `dout_valid`=0, `delay_err`=0.
  - RAM contents are not cleared; they are masked by `dout_valid`.

## Timing
- With `ce` held high, `din` sampled at cycle t appears on `dout` at cycle t+`delay_cur`.
- After reset release or after a load, the first valid sample is the first `din` written after the load cycle.
  - `dout_valid` rises exactly `delay_cur` `ce` cycles after that write, in the same cycle as that sample on `dout`.
- Gaps in `ce` stretch the latency in clocks; the delay counted in `ce` cycles is unchanged.
- `delay_cur` and `delay_err` update one cycle after `delay_load`.
- Reset asserted mid-stream forces `dout`/`dout_valid` low immediately, without waiting for a clock edge.

## Structure
- The `log2` function and the `DMIN` calculation go in the shared `general_lib` math package/include.
- Sub-module `bram_delay_ram`: single-port, read-before-write RAM.
  - Ports: `clk`, `ce`, `we`, `addr`, `din`, `dout`.
  - Contains `LATENCY` output registers, all gated by `ce`; no reset on the storage.
- The top level holds the counters, the clamp logic, the valid flag and the output mask.

## Test plan
- Reset, then `ce`=1 and a ramp on `din` (0, 1, 2, …) with `DEFAULT_DELAY`=1024 → `dout_valid` rises at cycle 1024 with `dout`=0, then `dout`=n−1024 every cycle.
- Load `delay`=5 with `LATENCY`=2, then ramp `din` → `dout_valid` goes low, rises 5 cycles after the first write, and `dout` tracks `din` delayed by 5.
- Load `delay`=1 (below `DMIN`=3), then `delay`=4000 → each load gives a `delay_err` pulse; `delay_cur` reads 3, then 1024.
- `delay`=8 with `ce` toggling 1,0,1,0,… → output delay is 8 `ce` cycles (16 clocks); `dout` holds during `ce`=0.
- Load `delay`=10 at fill 6, then `delay`=20 in the same cycle as `ce`=1 → the load-cycle `din` is dropped; `dout_valid` rises 20 writes later.
- Assert `rst_n`=0 mid-stream with `dout_valid`=1 → `dout`=0 and `dout_valid`=0 asynchronously; after release the fill restarts at `DEFAULT_DELAY`.

Source files
------------

// File: rtl/bram_delay_prog_pkg.sv
// rtl/bram_delay_prog_pkg.sv - shared math helpers and types for the programmable BRAM delay line
package bram_delay_prog_pkg;

  typedef enum logic [1:0] {
    CLAMP_NONE,
    CLAMP_LOW,
    CLAMP_HIGH
  } clamp_e;

  // Ceiling log2: number of bits needed to index `value` distinct entries.
  function automatic int log2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Shortest legal delay: RAM read latency plus one write-to-read cycle.
  function automatic int dmin(input int latency);
    return latency + 1;
  endfunction

endpackage

// File: rtl/bram_delay_ram.sv
// rtl/bram_delay_ram.sv - single-port read-before-write RAM with ce-gated output pipeline
module bram_delay_ram #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 1022,
  parameter int AW      = 10,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             ce,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_q;

  // Old contents are read out in the same cycle the new word is written.
  always_ff @(posedge clk) begin
    if (ce) begin
      if (we) mem_q[addr] <= din;
      rd_q <= mem_q[addr];
    end
  end

  if (LATENCY == 2) begin : g_lat2
    logic [WIDTH-1:0] lat_q;
    always_ff @(posedge clk) begin
      if (ce) lat_q <= rd_q;
    end
    assign dout = lat_q;
  end else begin : g_lat1
    assign dout = rd_q;
  end

endmodule

// File: rtl/bram_delay_prog.sv
// rtl/bram_delay_prog.sv - runtime-programmable, clock-enabled BRAM delay line
module bram_delay_prog
  import bram_delay_prog_pkg::*;
#(
  parameter int  WIDTH         = 32,
  parameter int  MAX_DELAY     = 1024,
  parameter int  LATENCY       = 2,
  parameter int  DEFAULT_DELAY = MAX_DELAY,
  localparam int DELAY_BITS    = log2(MAX_DELAY + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ce,
  input  logic [WIDTH-1:0]      din,
  input  logic [DELAY_BITS-1:0] delay,
  input  logic                  delay_load,
  output logic [WIDTH-1:0]      dout,
  output logic                  dout_valid,
  output logic                  delay_err,
  output logic [DELAY_BITS-1:0] delay_cur
);

  localparam int DEPTH    = MAX_DELAY - LATENCY;
  localparam int CTR_BITS = (log2(DEPTH) < 1) ? 1 : log2(DEPTH);
  localparam logic [DELAY_BITS-1:0] DMIN_V = DELAY_BITS'(dmin(LATENCY));
  localparam logic [DELAY_BITS-1:0] DMAX_V = DELAY_BITS'(MAX_DELAY);
  localparam logic [DELAY_BITS-1:0] DDEF_V = DELAY_BITS'(DEFAULT_DELAY);

  if (LATENCY != 1 && LATENCY != 2) begin : g_bad_latency
    $error("bram_delay_prog: LATENCY must be 1 or 2");
  end

  logic [CTR_BITS-1:0]   ctr_q, ctr_d;
  logic [DELAY_BITS-1:0] fill_q, fill_d;
  logic [DELAY_BITS-1:0] cur_q, cur_d;
  logic [DELAY_BITS-1:0] load_val;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic                  we;
  clamp_e                clamp;
  logic [WIDTH-1:0]      ram_dout;

  assign we = ce & ~delay_load;

  always_comb begin
    clamp    = CLAMP_NONE;
    load_val = delay;
    if (delay < DMIN_V) begin
      clamp    = CLAMP_LOW;
      load_val = DMIN_V;
    end else if (delay > DMAX_V) begin
      clamp    = CLAMP_HIGH;
      load_val = DMAX_V;
    end
  end

  // Counter period is delay_cur-LATENCY; the read pipeline supplies the rest.
  always_comb begin
    ctr_d  = ctr_q;
    fill_d = fill_q;
    cur_d  = cur_q;
    err_d  = delay_load && (clamp != CLAMP_NONE);
    if (delay_load) begin
      cur_d  = load_val;
      ctr_d  = '0;
      fill_d = '0;
    end else if (ce) begin
      ctr_d  = (DELAY_BITS'(ctr_q) == cur_q - DMIN_V) ? '0 : ctr_q + CTR_BITS'(1);
      fill_d = (fill_q == cur_q) ? fill_q : fill_q + DELAY_BITS'(1);
    end
    valid_d = (fill_d == cur_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr_q   <= '0;
      fill_q  <= '0;
      cur_q   <= DDEF_V;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ctr_q   <= ctr_d;
      fill_q  <= fill_d;
      cur_q   <= cur_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  bram_delay_ram #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .AW     (CTR_BITS),
    .LATENCY(LATENCY)
  ) u_ram (
    .clk (clk),
    .ce  (ce),
    .we  (we),
    .addr(ctr_q),
    .din (din),
    .dout(ram_dout)
  );

  // Stale RAM contents never leave the block: the mask follows the async-reset valid flag.
  assign dout       = valid_q ? ram_dout : '0;
  assign dout_valid = valid_q;
  assign delay_err  = err_q;
  assign delay_cur  = cur_q;

endmodule

// File: tb/tb_bram_delay_prog.sv
// tb/tb_bram_delay_prog.sv - self-checking bench for bram_delay_prog
module tb_bram_delay_prog;

  localparam int WIDTH     = 32;
  localparam int MAX_DELAY = 1024;
  localparam int LATENCY   = 2;
  localparam int DB        = 11;
  localparam int DMIN      = LATENCY + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ce;
  logic [WIDTH-1:0] din;
  logic [DB-1:0]    delay;
  logic             delay_load;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             delay_err;
  logic [DB-1:0]    delay_cur;

  int checks = 0;
  int fails  = 0;

  int               m_cur    = MAX_DELAY;
  int               m_writes = 0;
  int               m_req;
  bit               m_err    = 1'b0;
  logic [WIDTH-1:0] m_hist[$];

  bram_delay_prog #(
    .WIDTH        (WIDTH),
    .MAX_DELAY    (MAX_DELAY),
    .LATENCY      (LATENCY),
    .DEFAULT_DELAY(MAX_DELAY)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .din       (din),
    .delay     (delay),
    .delay_load(delay_load),
    .dout      (dout),
    .dout_valid(dout_valid),
    .delay_err (delay_err),
    .delay_cur (delay_cur)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Model: the line holds the last delay_cur written samples since the last load/reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cur    = MAX_DELAY;
      m_writes = 0;
      m_err    = 1'b0;
      m_hist.delete();
    end else begin
      m_err = 1'b0;
      if (delay_load) begin
        m_req    = int'(delay);
        m_err    = (m_req < DMIN) || (m_req > MAX_DELAY);
        m_cur    = (m_req < DMIN) ? DMIN : ((m_req > MAX_DELAY) ? MAX_DELAY : m_req);
        m_writes = 0;
        m_hist.delete();
      end else if (ce) begin
        m_hist.push_back(din);
        m_writes++;
        if (m_hist.size() > m_cur) void'(m_hist.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    check("dout_valid", 32'(dout_valid), 32'(m_writes >= m_cur));
    check("dout", dout, (m_writes >= m_cur) ? m_hist[0] : 32'd0);
    check("delay_cur", 32'(delay_cur), 32'(m_cur));
    check("delay_err", 32'(delay_err), 32'(m_err));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int d);
    delay      = DB'(d);
    delay_load = 1'b1;
    ce         = 1'b1;
    din        = 32'hDEAD_BEEF;
    tick();
    delay_load = 1'b0;
  endtask

  initial begin
    int rise;
    logic [WIDTH-1:0] d15;
    logic [WIDTH-1:0] d16;

    rst_n = 1'b0; ce = 1'b0; din = '0; delay = '0; delay_load = 1'b0;
    repeat (3) tick();
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_dout", dout, 32'd0);
    check("rst_cur", 32'(delay_cur), 32'd1024);
    check("rst_err", 32'(delay_err), 32'd0);
    rst_n = 1'b1;

    // Default delay 1024 with a ramp.
    rise = -1;
    for (int n = 0; n < 1100; n++) begin
      ce = 1'b1; din = n;
      tick();
      if (dout_valid && rise < 0) begin
        rise = n;
        check("t1_first_dout", dout, 32'd0);
      end
    end
    check("t1_rise", rise, 32'd1023);
    check("t1_tail", dout, 32'd76);

    // Short delay of 5.
    load(5);
    check("t2_valid_drop", 32'(dout_valid), 32'd0);
    check("t2_cur", 32'(delay_cur), 32'd5);
    check("t2_err", 32'(delay_err), 32'd0);
    rise = -1;
    for (int k = 0; k < 30; k++) begin
      din = 100 + k;
      tick();
      if (dout_valid && rise < 0) begin
        rise = k;
        check("t2_first_dout", dout, 32'd100);
      end
    end
    check("t2_rise", rise, 32'd4);
    check("t2_tail", dout, 32'd125);

    // Clamping at both ends and the exact boundaries.
    load(1);
    check("t3_low_err", 32'(delay_err), 32'd1);
    check("t3_low_cur", 32'(delay_cur), 32'd3);
    ce = 1'b0;
    tick();
    check("t3_err_pulse", 32'(delay_err), 32'd0);
    load(4000);
    check("t3_high_err", 32'(delay_err), 32'd1);
    check("t3_high_cur", 32'(delay_cur), 32'd1024);
    load(3);
    check("t3_min_err", 32'(delay_err), 32'd0);
    check("t3_min_cur", 32'(delay_cur), 32'd3);
    load(1024);
    check("t3_max_err", 32'(delay_err), 32'd0);

    // Delay 8 with ce toggling every clock.
    load(8);
    rise = -1; d15 = '0; d16 = '0;
    for (int k = 0; k < 60; k++) begin
      ce  = (k % 2 == 0);
      din = 200 + k;
      tick();
      if (dout_valid && rise < 0) begin
        rise = k;
        check("t4_first_dout", dout, 32'd200);
      end
      if (k == 15) d15 = dout;
      if (k == 16) d16 = dout;
    end
    check("t4_rise", rise, 32'd14);
    check("t4_hold", d15, 32'd200);
    check("t4_next", d16, 32'd202);

    // Reload mid-fill; the load-cycle din is dropped.
    load(10);
    for (int k = 0; k < 6; k++) begin
      ce = 1'b1; din = 300 + k;
      tick();
    end
    check("t5_partial_valid", 32'(dout_valid), 32'd0);
    load(20);
    rise = -1;
    for (int k = 0; k < 40; k++) begin
      ce = 1'b1; din = 400 + k;
      tick();
      if (dout_valid && rise < 0) begin
        rise = k;
        check("t5_first_dout", dout, 32'd400);
      end
    end
    check("t5_rise", rise, 32'd19);

    // Asynchronous reset mid-stream.
    check("t6_pre_valid", 32'(dout_valid), 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t6_async_valid", 32'(dout_valid), 32'd0);
    check("t6_async_dout", dout, 32'd0);
    check("t6_async_cur", 32'(delay_cur), 32'd1024);
    tick();
    tick();
    rst_n = 1'b1;
    rise = -1;
    for (int n = 0; n < 1030; n++) begin
      ce = 1'b1; din = 5000 + n;
      tick();
      if (dout_valid && rise < 0) begin
        rise = n;
        check("t6_first_dout", dout, 32'd5000);
      end
    end
    check("t6_rise", rise, 32'd1023);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
